// File: rtl/gen_inv_round_keys.sv
// AES-128 decryption round-key generator: expands the cipher key forward to K10, then walks K10..K0 on request.
// Build macro INV_KEY_SELFCHECK_EN adds a sticky flag raised when the regenerated K0 differs from the loaded key.

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    // Multiplicative inverse computed as x^254 in GF(2^8), then the standard affine transform.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_x252, w_inv;

    assign w_x2   = gf_mul(i_byte, i_byte);
    assign w_x3   = gf_mul(w_x2, i_byte);
    assign w_x6   = gf_mul(w_x3, w_x3);
    assign w_x12  = gf_mul(w_x6, w_x6);
    assign w_x15  = gf_mul(w_x12, w_x3);
    assign w_x30  = gf_mul(w_x15, w_x15);
    assign w_x60  = gf_mul(w_x30, w_x30);
    assign w_x120 = gf_mul(w_x60, w_x60);
    assign w_x240 = gf_mul(w_x120, w_x120);
    assign w_x252 = gf_mul(w_x240, w_x12);
    assign w_inv  = gf_mul(w_x252, w_x2);

    assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module gen_inv_round_keys #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         key_next,
    output logic         key_busy,
    output logic         key_valid,
    output logic [127:0] round_key,
    output logic [3:0]   key_round,
    output logic         key_err
);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       r_state, w_state_nxt;
    logic [127:0] r_key, w_key_nxt;
    logic [127:0] r_last, w_last_nxt;
    logic [3:0]   r_round, w_round_nxt;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_sub_in, w_rot, w_sub, w_temp;
    logic [127:0] w_fwd, w_inv;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;

    // One shared set of four S-boxes: forward rounds take w3 directly, inverse steps rebuild the older w3 first.
    assign w_sub_in = (r_state == EXPAND) ? w_w3 : (w_w3 ^ w_w2);
    assign w_rot    = {w_sub_in[23:0], w_sub_in[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.i_byte(w_rot[8*g +: 8]), .o_byte(w_sub[8*g +: 8]));
    end

    assign w_temp = w_sub ^ {rcon(r_round), 24'h000000};

    always_comb begin
        logic [31:0] f0, f1, f2, f3;
        f0    = w_w0 ^ w_temp;
        f1    = w_w1 ^ f0;
        f2    = w_w2 ^ f1;
        f3    = w_w3 ^ f2;
        w_fwd = {f0, f1, f2, f3};
        w_inv = {w_w0 ^ w_temp, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};
    end

    always_comb begin
        // NOTE: every next-value gets its hold default first so no path leaves it unassigned (no latches).
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_last_nxt  = r_last;
        w_round_nxt = r_round;

        case (r_state)
            EXPAND: begin
                w_key_nxt = w_fwd;
                if (r_round == LAST_ROUND) begin
                    w_last_nxt  = w_fwd;
                    w_state_nxt = READY;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
            READY: begin
                if (key_next) begin
                    if (r_round != 4'd0) begin
                        w_key_nxt   = w_inv;
                        w_round_nxt = r_round - 4'd1;
                    end else begin
                        w_key_nxt   = r_last;
                        w_round_nxt = LAST_ROUND;
                    end
                end
            end
            default: ;
        endcase

        if (key_load) begin
            w_key_nxt   = key_in;
            w_round_nxt = 4'd1;
            w_state_nxt = EXPAND;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_last  <= '0;
            r_round <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_last  <= w_last_nxt;
            r_round <= w_round_nxt;
        end
    end

    assign key_busy  = (r_state == EXPAND);
    assign key_valid = (r_state == READY);
    assign round_key = key_valid ? r_key : '0;
    assign key_round = key_valid ? r_round : 4'd0;

`ifdef INV_KEY_SELFCHECK_EN
    logic [127:0] r_orig;
    logic         r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_orig <= '0;
            r_err  <= 1'b0;
        end else if (key_load) begin
            r_orig <= key_in;
            r_err  <= 1'b0;
        end else if (r_state == READY && r_round == 4'd0 && r_key != r_orig) begin
            r_err <= 1'b1;
        end
    end

    assign key_err = r_err;
`else
    assign key_err = 1'b0;
`endif
endmodule

// File: tb/tb_gen_inv_round_keys.sv
// Scoreboard bench for gen_inv_round_keys using the FIPS-197 A.1 and C.1 key schedules.
module tb_gen_inv_round_keys;
    logic         clk = 1'b0;
    logic         rst, key_load, key_next;
    logic [127:0] key_in;
    logic         key_busy, key_valid, key_err;
    logic [127:0] round_key;
    logic [3:0]   key_round;

    always #5 clk = ~clk;

    gen_inv_round_keys #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .key_next(key_next),
        .key_busy(key_busy), .key_valid(key_valid), .round_key(round_key),
        .key_round(key_round), .key_err(key_err)
    );

    localparam logic [127:0] FIPS_K [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    localparam logic [127:0] C_K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_K1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] C_K9  = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] C_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        bit           chk_key;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] rnd, input logic [127:0] key, input bit chk_key);
        exp_t e;
        e.rnd = rnd;
        e.key = key;
        e.chk_key = chk_key;
        q.push_back(e);
    endtask

    // Monitor: each new (valid, round, key) presentation consumes one scoreboard entry.
    logic         prev_valid = 1'b0;
    logic [3:0]   prev_round = 4'd0;
    logic [127:0] prev_key   = '0;

    always @(negedge clk) begin
        if (key_valid === 1'b1 &&
            (!prev_valid || key_round !== prev_round || round_key !== prev_key)) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mon_unexpected: got round %0d key %h expected no new output",
                         key_round, round_key);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("mon_round", 128'(key_round), 128'(e.rnd));
                if (e.chk_key) check("mon_key", round_key, e.key);
            end
        end
        prev_valid <= key_valid;
        prev_round <= key_round;
        prev_key   <= round_key;
    end

    task automatic check_zero(input string name);
        check({name, "_busy"}, 128'(key_busy), 128'(0));
        check({name, "_valid"}, 128'(key_valid), 128'(0));
        check({name, "_round"}, 128'(key_round), 128'(0));
        check({name, "_key"}, round_key, 128'(0));
        check({name, "_err"}, 128'(key_err), 128'(0));
    endtask

    // Starts and ends on a falling edge; optionally pulses key_next during expansion.
    task automatic load_key(input logic [127:0] k, input logic [127:0] k10, input bit pulse_next);
        push(4'd10, k10, 1'b1);
        key_in   = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("expand_busy", 128'(key_busy), 128'(1));
            check("expand_valid", 128'(key_valid), 128'(0));
            key_next = pulse_next && (i % 3 == 0);
            @(negedge clk);
        end
        key_next = 1'b0;
        check("ready_busy", 128'(key_busy), 128'(0));
        check("ready_valid", 128'(key_valid), 128'(1));
    endtask

    task automatic step(input logic [3:0] rnd, input logic [127:0] key, input bit chk_key);
        push(rnd, key, chk_key);
        key_next = 1'b1;
        @(negedge clk);
        key_next = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        key_load = 1'b1;
        key_next = 1'b1;
        key_in   = FIPS_K[0];
        repeat (2) @(negedge clk);
        check_zero("reset");

        rst      = 1'b0;
        key_load = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_next_valid", 128'(key_valid), 128'(0));
        key_next = 1'b0;

        load_key(FIPS_K[0], FIPS_K[10], 1'b1);
        repeat (5) @(negedge clk);
        check("hold_round", 128'(key_round), 128'(10));
        check("hold_key", round_key, FIPS_K[10]);

        for (int r = 9; r >= 0; r--) step(4'(r), FIPS_K[r], 1'b1);
        @(negedge clk);
        check("k0_err", 128'(key_err), 128'(0));

        step(4'd10, FIPS_K[10], 1'b1);
        check("wrap_valid", 128'(key_valid), 128'(1));

        for (int r = 9; r >= 5; r--) step(4'(r), FIPS_K[r], 1'b1);
        load_key(C_K0, C_K10, 1'b0);
        step(4'd9, C_K9, 1'b1);
        for (int r = 8; r >= 2; r--) step(4'(r), '0, 1'b0);
        step(4'd1, C_K1, 1'b1);
        step(4'd0, C_K0, 1'b1);

        key_in   = FIPS_K[0];
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("rst_expand");
        rst      = 1'b0;
        key_next = 1'b1;
        repeat (3) @(negedge clk);
        key_next = 1'b0;
        check("post_rst_valid", 128'(key_valid), 128'(0));
        check("post_rst_busy", 128'(key_busy), 128'(0));

        load_key(FIPS_K[0], FIPS_K[10], 1'b0);
        step(4'd9, FIPS_K[9], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("rst_ready");
        rst = 1'b0;
        @(negedge clk);

`ifdef INV_KEY_SELFCHECK_EN
        load_key(FIPS_K[0], FIPS_K[10], 1'b0);
        for (int r = 9; r >= 0; r--) step(4'(r), FIPS_K[r], 1'b1);
        force dut.r_last = FIPS_K[10] ^ 128'h1;
        step(4'd10, FIPS_K[10] ^ 128'h1, 1'b1);
        for (int r = 9; r >= 0; r--) step(4'(r), '0, 1'b0);
        check("err_before", 128'(key_err), 128'(0));
        @(negedge clk);
        check("err_set", 128'(key_err), 128'(1));
        repeat (3) @(negedge clk);
        check("err_sticky", 128'(key_err), 128'(1));
        release dut.r_last;
        load_key(FIPS_K[0], FIPS_K[10], 1'b0);
        check("err_cleared", 128'(key_err), 128'(0));
`endif

        repeat (3) @(negedge clk);
        check("queue_empty", 128'(q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gen_inv_round_keys.md
GEN_INV_ROUND_KEYS -- requirements
Module: gen_inv_round_keys

Interface
REQ-001 Parameter: NUM_ROUNDS, 10, AES-128 round count; only 10 is supported.
REQ-002 Port: clk  in  1  sole clock; all logic on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: key_load  in  1  single-cycle request to accept key_in and start expansion.
REQ-005 Port: key_in  in  128  cipher key (round-0 key), MSB = byte 0.
REQ-006 Port: key_next  in  1  consumer acknowledge; step to the previous round key.
REQ-007 Port: key_busy  out  1  forward expansion in progress.
REQ-008 Port: key_valid  out  1  round_key/key_round valid.
REQ-009 Port: round_key  out  128  current decryption round key.
REQ-010 Port: key_round  out  4  round index of round_key, 10 down to 0.
REQ-011 Port: key_err  out  1  sticky self-check mismatch flag (see Configuration).

Function
REQ-012 States SHALL be IDLE, EXPAND and READY; reset enters IDLE.
REQ-013 key_load sampled high in any state SHALL capture key_in into an original-key register and enter EXPAND with the round counter at 1; it SHALL override key_next.
REQ-014 EXPAND SHALL compute one forward round per cycle: w0' = w0^SubWord(RotWord(w3))^{rcon[r],24'h0}; wi' = wi^w(i-1)' for i = 1..3. rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
REQ-015 Per-cycle S-box lookups SHALL be limited to 4, using the team's SBox block.
REQ-016 key_busy SHALL be high for exactly the 10 cycles after the key_load cycle; key_valid SHALL be low during EXPAND.
REQ-017 After round 10, the block SHALL store K10 in a last-key register and enter READY, with key_valid=1, key_round=10, round_key=K10 in the 11th cycle after key_load.
REQ-018 In READY, key_next with key_round=r>0 SHALL present K(r-1) on the next cycle via the inverse recurrence: wi = wi'^w(i-1)' for i = 3..1; w0 = w0'^SubWord(RotWord(w3))^{rcon[r],24'h0}.
REQ-019 key_next with key_round=0 SHALL wrap: the next cycle presents K10 from the last-key register with key_round=10, and key_valid stays high.
REQ-020 key_next SHALL be ignored while key_valid=0.
REQ-021 Without key_next, round_key/key_round SHALL hold indefinitely.
REQ-022 key_load in READY SHALL drop key_valid on the next cycle and restart expansion per REQ-013.
REQ-023 All arithmetic SHALL be 128-bit XOR/byte-substitution only, with no carries; key_round SHALL never exceed 10.

Reset
REQ-024 On rst: state=IDLE, key_busy=0, key_valid=0, key_round=0, round_key=0, key_err=0, and all key registers cleared.
REQ-025 rst SHALL take priority over key_load and key_next; rst mid-EXPAND or mid-READY SHALL abort with no partial key visible afterwards.

Configuration
REQ-026 Macro INV_KEY_SELFCHECK_EN defined: each time key_round reaches 0, round_key SHALL be compared with the original-key register, and a mismatch SHALL set key_err on the next cycle. key_err stays set until rst or key_load.
REQ-027 Macro INV_KEY_SELFCHECK_EN undefined: key_err SHALL be tied to 0, no comparator SHALL be built, and all other behaviour SHALL be identical.

Verification
REQ-028 rst, then key_load with key_in=2b7e151628aed2a6abf7158809cf4f3c -> key_busy high for 10 cycles; next cycle key_valid=1, key_round=10, round_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-029 Same key, one key_next -> key_round=9, round_key=ac7766f319fadc2128d12941575c006e; 10 key_next total -> key_round=0, round_key=2b7e1516...09cf4f3c, key_err=0.
REQ-030 At key_round=0, key_next -> key_round=10, round_key=d014f9a8...b6630ca6 on the next cycle; key_valid never drops.
REQ-031 key_next pulses during EXPAND, and key_load of a new key at key_round=5 -> EXPAND pulses ignored; key_valid drops and the new K10 appears 11 cycles later.
REQ-032 rst asserted on the 4th EXPAND cycle -> all outputs 0 next cycle; later key_next is ignored until a new key_load completes.
REQ-033 With INV_KEY_SELFCHECK_EN, force a bit flip in the last-key register and step to round 0 -> key_err=1; it clears on key_load.
